// File: rtl/shift_right_seq.sv
// ---------------------------------------------------------------------------
// shift_right_seq
//
// Multi-cycle right shifter for the SRL/SRA instructions. It shifts the operand
// one bit per clock under a start/busy/done handshake. The control unit stalls
// the pipeline while busy is high and captures salida when done pulses.
//
// Parameters:
//   W  - data width (a power of two, at least 2)
//   SW - shift-amount width, $clog2(W)
//
// Ports:
//   clk     - single clock; all state changes on the rising edge
//   rst_n   - asynchronous active-low reset
//   start   - request a shift; accepted whenever busy is low
//   entrada - operand, sampled when start is accepted
//   shamt   - shift amount 0..W-1, sampled with entrada
//   arith   - 1 = SRA (sign fill), 0 = SRL (zero fill), sampled with entrada
//   salida  - result register; holds the last completed result
//   busy    - high exactly while a shift is in progress
//   done    - one-cycle pulse in the cycle salida first shows a new result
// ---------------------------------------------------------------------------
module shift_right_seq #(
  parameter int W  = 32,
  parameter int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  entrada,
  input  logic [SW-1:0] shamt,
  input  logic          arith,
  output logic [W-1:0]  salida,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  work;
  logic [SW-1:0] cnt;
  logic          fill;

  // The work register shifted by one place, with the fill bit entering from
  // the top. This is both the next work value and, on the last step, the
  // final result.
  logic [W-1:0]  shifted;

  // Build the one-bit right shift of the work register from the fill bit
  // that was captured when the operation was accepted.
  always_comb begin
    shifted = {fill, work[W-1:1]};
  end

  // The whole controller lives here: state, datapath registers and the
  // registered busy/done outputs. A new request is accepted from IDLE and
  // also from DONE, so back-to-back operations lose no cycle. busy and done
  // are written together with the state so that they always follow it
  // exactly: busy is high only in SHIFT and done is high only in DONE.
  // The counter holds the number of shift steps still to do. The step taken
  // while it reads 1 is the last one, so the result is written into salida
  // at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      fill   <= 1'b0;
      salida <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work <= entrada;
            cnt  <= shamt;
            fill <= arith & entrada[W-1];
            if (shamt == '0) begin
              salida <= entrada;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              state  <= SHIFT;
              busy   <= 1'b1;
              done   <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end

        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            salida <= shifted;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_right_seq.md
# shift_right_seq

Multi-cycle right shifter for the datapath's SRL/SRA instructions, shifting one bit per clock under a start/busy/done handshake. It is the right-direction counterpart to the combinational left-shift units that form jump and branch target addresses. It sits beside the ALU in the execute stage. The control unit stalls the pipeline while `busy` is high and captures `salida` when `done` pulses.

## Interface
- `W`, default 32: data width. Must be a power of two, at least 2.
- `SW`, default $clog2(W): shift-amount width (5 for W = 32).

Ports (name, direction, width, meaning):
- `clk`: input, 1. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1. Asynchronous, active-low reset.
- `start`: input, 1. Request a shift. Sampled on the rising edge.
- `entrada`: input, W. Operand. Sampled only when `start` is accepted.
- `shamt`: input, SW. Shift amount, 0 to W-1. Sampled with `entrada`.
- `arith`: input, 1. 1 selects SRA (sign fill); 0 selects SRL (zero fill). Sampled with `entrada`.
- `salida`: output, W. Result register. Holds the last completed result.
- `busy`: output, 1. High while a shift is in progress. `start` is ignored while `busy` is high.
- `done`: output, 1. Single-cycle pulse, high in the cycle `salida` first shows a new result.

## Operation
- FSM states:
  - IDLE: no operation in progress.
  - SHIFT: shifting in progress.
  - DONE: one cycle, `done` = 1.
- Start acceptance: `start` is accepted in IDLE or DONE, i.e. whenever `busy` = 0.
- On acceptance:
  - Latch `entrada` into the work register, `shamt` into the down-counter, and the fill bit (`arith` & `entrada[W-1]`).
  - If `shamt` = 0: go to DONE and load `salida` with `entrada` unchanged.
  - Otherwise: go to SHIFT.
- In SHIFT, each cycle:
  - work <= {fill, work[W-1:1]}; counter <= counter - 1.
  - When the counter reaches 1 in SHIFT, that cycle's shift is the last one. At that edge, `salida` <= the shifted value and the FSM moves to DONE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - Next state is SHIFT or DONE if `start` is accepted (back-to-back operation), else IDLE.
- `salida` changes only at the edge entering DONE. It holds its value through IDLE and through any later SHIFT.
- `busy` = 1 exactly while the state is SHIFT.
- The fill bit is fixed at acceptance. SRL always fills with 0. SRA replicates the original `entrada[W-1]`.
- Any `shamt` value is a legal shift. No wrap-around or modulo behaviour is needed beyond SW bits.
- `start` with `busy` = 1 is dropped. No queuing, no error flag.

## Timing
- Reset (`rst_n` = 0, any time, asynchronous):
  - State IDLE; `salida` = 0; `busy` = 0; `done` = 0; work register and counter = 0.
  - Reset in mid-operation aborts the shift; no `done` is produced for it.
  - Deassertion is synchronous to `clk` through the existing reset synchroniser.
- Latency, with `start` accepted at edge k:
  - `shamt` = 0: `done` and the new `salida` are visible after edge k+1's predecessor, i.e. in cycle k+1 (one cycle after acceptance); `busy` never rises.
  - `shamt` = n > 0: `busy` is high for cycles k+1 to k+n; `done` and the new `salida` appear in cycle k+n+1.
- Throughput: a new `start` in the DONE cycle is accepted. Minimum spacing between operations is n+1 cycles.
- `entrada`, `shamt` and `arith` may change freely after acceptance without affecting the operation in flight.

## Test plan
- SRL: `entrada` = 32'h8000_00F0, `shamt` = 4, `arith` = 0 -> `busy` high for 4 cycles; `done` in cycle 5; `salida` = 32'h0800_000F.
- SRA with the same operands, `arith` = 1 -> `salida` = 32'hF800_000F, same timing. Also `entrada` = 32'h8000_0000, `shamt` = 31, `arith` = 1 -> `salida` = 32'hFFFF_FFFF, `done` in cycle 32.
- Zero shift: `entrada` = 32'h0000_004F, `shamt` = 0 -> `busy` never high; `done` in the next cycle; `salida` = 32'h0000_004F.
- Start while busy: start 32'h0000_0100 with `shamt` = 8, then pulse `start` with 32'hFFFF_FFFF in cycle 3 -> second request ignored; `salida` = 32'h0000_0001; exactly one `done`.
- Back-to-back: `start` held high in the DONE cycle with 32'h0000_0023 and `shamt` = 2 -> second operation runs; `salida` = 32'h0000_0008, with `done` 3 cycles after the first `done`.
- Reset mid-op: assert `rst_n` = 0 during cycle 2 of a `shamt` = 10 shift -> `salida` = 0, `busy` = 0, `done` = 0 immediately. No `done` after release. A fresh `start` then works normally.
